video_timing_generator: RTL



---
 rtl/video_timing_generator_pkg.sv | 26 ++
 rtl/video_timing_generator_delay_line.sv | 32 +++
 rtl/video_timing_generator.sv | 108 ++++++++++
 3 files changed

// File: rtl/video_timing_generator_pkg.sv
// video_timing_generator_pkg: shared video constants for the 640x480@60 raster.
// Holds the timing defaults, counter and address widths, and the payload
// carried through the read-latency delay line together with its reset value.
package video_timing_generator_pkg;
    localparam int DEF_H_VISIBLE    = 640;
    localparam int DEF_H_FRONT      = 16;
    localparam int DEF_H_SYNC       = 96;
    localparam int DEF_H_BACK       = 48;
    localparam int DEF_V_VISIBLE    = 480;
    localparam int DEF_V_FRONT      = 10;
    localparam int DEF_V_SYNC       = 2;
    localparam int DEF_V_BACK       = 33;
    localparam int DEF_READ_LATENCY = 1;
    localparam int CNT_W            = 10;
    localparam int ADDR_W           = 19;

    typedef struct packed {
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             vis;
        logic             hsync_n;
        logic             vsync_n;
    } timing_t;

    localparam timing_t TIMING_RST = '{x: '0, y: '0, vis: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};
endpackage

// File: rtl/video_timing_generator_delay_line.sv
// video_delay_line: enable-gated shift register, DEPTH stages of WIDTH bits.
// Ports: clock, reset (async, active-high), i_en (shift strobe),
//        i_d (stage-0 input), o_q (last stage; equals i_d when DEPTH=0).
// Every stage resets to RESET_VAL.
module video_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end
            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/video_timing_generator.sv
// video_timing_generator: VGA raster timing with frame-memory latency alignment.
// Ports: clock, reset (async, active-high), pixel_enable (pixel tick);
//        frame_address (read address of the current undelayed pixel),
//        pixel_x_pos/pixel_y_pos, video_active, vga_hsync/vga_vsync (active-low),
//        vga_blank_n -- all delayed READ_LATENCY ticks to meet the read data;
//        frame_start (pulse on the tick the counters wrap to (0,0)).
// Build option: VIDEO_PIXEL_DOUBLING_EN selects a 320x240 doubled address map.
module video_timing_generator
    import video_timing_generator_pkg::*;
#(
    parameter int H_VISIBLE    = DEF_H_VISIBLE,
    parameter int H_FRONT      = DEF_H_FRONT,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BACK       = DEF_H_BACK,
    parameter int V_VISIBLE    = DEF_V_VISIBLE,
    parameter int V_FRONT      = DEF_V_FRONT,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BACK       = DEF_V_BACK,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pixel_enable,
    output logic [ADDR_W-1:0] frame_address,
    output logic [CNT_W-1:0]  pixel_x_pos,
    output logic [CNT_W-1:0]  pixel_y_pos,
    output logic              video_active,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic              frame_start
);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [CNT_W-1:0]  r_h, r_v, w_h_nxt, w_v_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              w_h_wrap, w_v_wrap, w_nxt_vis;
    timing_t           w_tm, w_dl;

    // Shift-add only: y*640 = (y<<9)+(y<<7); doubled y*320 = (y<<8)+(y<<6).
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
        logic [ADDR_W-1:0] vy, hx;
`ifdef VIDEO_PIXEL_DOUBLING_EN
        vy = ADDR_W'(v >> 1);
        hx = ADDR_W'(h >> 1);
        return (vy << 8) + (vy << 6) + hx;
`else
        vy = ADDR_W'(v);
        hx = ADDR_W'(h);
        return (vy << 9) + (vy << 7) + hx;
`endif
    endfunction

    assign w_h_wrap  = r_h == H_LAST;
    assign w_v_wrap  = r_v == V_LAST;
    assign w_h_nxt   = w_h_wrap ? '0 : r_h + 1'b1;
    assign w_v_nxt   = w_h_wrap ? (w_v_wrap ? '0 : r_v + 1'b1) : r_v;
    assign w_nxt_vis = w_h_nxt < H_VIS && w_v_nxt < V_VIS;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h    <= '0;
            r_v    <= '0;
            r_addr <= '0;
        end else if (pixel_enable) begin
            r_h    <= w_h_nxt;
            r_v    <= w_v_nxt;
            // Computed from the next counts so the address lines up with the counters it names.
            r_addr <= w_nxt_vis ? pix_addr(w_h_nxt, w_v_nxt) : '0;
        end
    end

    assign w_tm = '{
        x:       r_h,
        y:       r_v,
        vis:     r_h < H_VIS && r_v < V_VIS,
        hsync_n: !(r_h >= H_SS && r_h < H_SE),
        vsync_n: !(r_v >= V_SS && r_v < V_SE)
    };

    video_delay_line #(
        .WIDTH     ($bits(timing_t)),
        .DEPTH     (READ_LATENCY),
        .RESET_VAL (TIMING_RST)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .i_en  (pixel_enable),
        .i_d   (w_tm),
        .o_q   (w_dl)
    );

    assign frame_address = r_addr;
    assign pixel_x_pos   = w_dl.x;
    assign pixel_y_pos   = w_dl.y;
    assign video_active  = w_dl.vis;
    assign vga_blank_n   = w_dl.vis;
    assign vga_hsync     = w_dl.hsync_n;
    assign vga_vsync     = w_dl.vsync_n;
    assign frame_start   = pixel_enable && w_h_wrap && w_v_wrap;
endmodule
